// File: rtl/traffic_timer_pkg.sv
// Shared encodings and defaults for the traffic-light interval timer.
// Duration selects, the timer state enum and the reset-time durations live here
// so the FSM and the timer agree on one set of values.
package traffic_timer_pkg;

   // Duration select encoding used by both timeParameter and progSel.
   localparam logic [1:0] TP_BASE = 2'd0;
   localparam logic [1:0] TP_EXT  = 2'd1;
   localparam logic [1:0] TP_YEL  = 2'd2;
   localparam logic [1:0] TP_NONE = 2'd3;

   // Reset-time durations, in seconds.
   localparam int unsigned T_BASE_DEFAULT = 6;
   localparam int unsigned T_EXT_DEFAULT  = 3;
   localparam int unsigned T_YEL_DEFAULT  = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } timer_state_e;

   // Divider counter width; a divide-by-one still needs one bit of storage.
   function automatic int unsigned div_width(input int unsigned div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/interval_timer_ctrl_tick_divider.sv
// tick_divider: free-running 0..TICK_DIV-1 counter with synchronous clear.
// tick is high during the cycle whose edge wraps the counter while enabled.
module tick_divider
   import traffic_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tick
);

   localparam int unsigned     DIV_W    = div_width(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   // Next divider value: clear dominates, otherwise advance and wrap when enabled.
   always_comb begin
      div_d = div_q;
      if (clear) begin
         div_d = '0;
      end else if (en) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      end
   end

   assign tick = en && !clear && (div_q == DIV_LAST);

   // Divider register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

endmodule

// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl: programmable interval timer for the traffic-light FSM.
// Holds the base/extended/yellow durations, loads one on startTimer and counts
// it down in second ticks, returning a one-cycle expired pulse.
// Optional build macro TIMER_PAUSE_EN adds a hold input that freezes counting.
//
//   state | meaning
//   IDLE  | waiting for startTimer, remaining held at 0
//   COUNT | counting down, busy=1
//   DONE  | single cycle with expired=1, then back to IDLE
module interval_timer_ctrl
   import traffic_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 4,
   parameter int unsigned CNT_W      = 4,
   parameter int unsigned T_BASE_DEF = T_BASE_DEFAULT,
   parameter int unsigned T_EXT_DEF  = T_EXT_DEFAULT,
   parameter int unsigned T_YEL_DEF  = T_YEL_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             startTimer,
   input  logic [1:0]       timeParameter,
   input  logic             reprogram,
   input  logic [1:0]       progSel,
   input  logic [CNT_W-1:0] progValue,
`ifdef TIMER_PAUSE_EN
   input  logic             hold,
`endif
   output logic             expired,
   output logic             busy,
   output logic [CNT_W-1:0] remaining
);

   timer_state_e     state_q;
   timer_state_e     state_d;
   logic [CNT_W-1:0] remaining_q;
   logic [CNT_W-1:0] remaining_d;
   logic [CNT_W-1:0] dur_base_q;
   logic [CNT_W-1:0] dur_base_d;
   logic [CNT_W-1:0] dur_ext_q;
   logic [CNT_W-1:0] dur_ext_d;
   logic [CNT_W-1:0] dur_yel_q;
   logic [CNT_W-1:0] dur_yel_d;
   logic [CNT_W-1:0] sel_dur;
   logic             hold_active;
   logic             div_clear;
   logic             div_en;
   logic             tick;
   logic             last_tick;
   logic             prog_wr;

`ifdef TIMER_PAUSE_EN
   assign hold_active = hold;
`else
   assign hold_active = 1'b0;
`endif

   // The divider only runs in COUNT; any start restarts the second from zero.
   assign div_clear = startTimer || (state_q != COUNT);
   assign div_en    = (state_q == COUNT) && !hold_active;
   assign last_tick = tick && (remaining_q == CNT_W'(1));

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_divider (
      .clk   (clk),
      .reset (reset),
      .clear (div_clear),
      .en    (div_en),
      .tick  (tick)
   );

   // Duration selected by the request; reads the registered (pre-write) values.
   always_comb begin
      case (timeParameter)
         TP_EXT:  sel_dur = dur_ext_q;
         TP_YEL:  sel_dur = dur_yel_q;
         default: sel_dur = dur_base_q;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a start always wins, including over the final tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (startTimer) state_d = COUNT;
         end
         COUNT: begin
            if (startTimer)     state_d = COUNT;
            else if (last_tick) state_d = DONE;
         end
         DONE: begin
            state_d = startTimer ? COUNT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state; remaining is the live count.
   always_comb begin
      expired   = (state_q == DONE);
      busy      = (state_q == COUNT);
      remaining = remaining_q;
   end

   // Countdown: load on start, decrement on tick, zero outside COUNT.
   always_comb begin
      remaining_d = remaining_q;
      if (startTimer) begin
         remaining_d = sel_dur;
      end else if (state_q == COUNT) begin
         if (tick) remaining_d = remaining_q - CNT_W'(1);
      end else begin
         remaining_d = '0;
      end
   end

   // Countdown register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         remaining_q <= '0;
      end else begin
         remaining_q <= remaining_d;
      end
   end

   // Duration writes; zero is rejected so every interval lasts at least a second.
   assign prog_wr = reprogram && (progSel != TP_NONE) && (progValue != '0);

   // Duration register next values from the write decode.
   always_comb begin
      dur_base_d = dur_base_q;
      dur_ext_d  = dur_ext_q;
      dur_yel_d  = dur_yel_q;
      if (prog_wr) begin
         case (progSel)
            TP_BASE: dur_base_d = progValue;
            TP_EXT:  dur_ext_d  = progValue;
            TP_YEL:  dur_yel_d  = progValue;
            default: ;
         endcase
      end
   end

   // Duration registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dur_base_q <= CNT_W'(T_BASE_DEF);
         dur_ext_q  <= CNT_W'(T_EXT_DEF);
         dur_yel_q  <= CNT_W'(T_YEL_DEF);
      end else begin
         dur_base_q <= dur_base_d;
         dur_ext_q  <= dur_ext_d;
         dur_yel_q  <= dur_yel_d;
      end
   end

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// Testbench for interval_timer_ctrl. Reference model works in elapsed clock
// cycles: remaining = N - elapsed/TICK_DIV, expiry when elapsed reaches N*TICK_DIV.
// Build with TIMER_PAUSE_EN defined to exercise the hold input as well.
module tb_interval_timer_ctrl;

   localparam int D = 4;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         startTimer;
   logic [1:0]   timeParameter;
   logic         reprogram;
   logic [1:0]   progSel;
   logic [W-1:0] progValue;
   logic         hold;
   logic         expired;
   logic         busy;
   logic [W-1:0] remaining;

   int checks   = 0;
   int failures = 0;

   int m_dur [3];
   bit m_active;
   bit m_exp;
   int m_n;
   int m_elapsed;

   always #5 clk = ~clk;

   interval_timer_ctrl #(
      .TICK_DIV   (D),
      .CNT_W      (W),
      .T_BASE_DEF (6),
      .T_EXT_DEF  (3),
      .T_YEL_DEF  (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .startTimer    (startTimer),
      .timeParameter (timeParameter),
      .reprogram     (reprogram),
      .progSel       (progSel),
      .progValue     (progValue),
`ifdef TIMER_PAUSE_EN
      .hold          (hold),
`endif
      .expired       (expired),
      .busy          (busy),
      .remaining     (remaining)
   );

   function automatic int m_rem();
      return m_active ? (m_n - m_elapsed / D) : 0;
   endfunction

   task automatic model_reset();
      m_dur     = '{6, 3, 2};
      m_active  = 1'b0;
      m_exp     = 1'b0;
      m_n       = 0;
      m_elapsed = 0;
   endtask

   task automatic drive_idle();
      startTimer    = 1'b0;
      timeParameter = 2'd0;
      reprogram     = 1'b0;
      progSel       = 2'd3;
      progValue     = '0;
      hold          = 1'b0;
   endtask

   // One clock edge: update the model from the inputs seen at the edge, then
   // step past the edge so outputs can be sampled.
   task automatic tick_edge();
      @(posedge clk);
      if (!reset) begin
         model_reset();
      end else begin
         m_exp = 1'b0;
         if (startTimer) begin
            m_n       = m_dur[(timeParameter == 2'd3) ? 0 : int'(timeParameter)];
            m_active  = 1'b1;
            m_elapsed = 0;
         end else if (m_active) begin
            if (!hold) m_elapsed++;
            if (m_elapsed == m_n * D) begin
               m_active = 1'b0;
               m_exp    = 1'b1;
            end
         end
         if (reprogram && progSel != 2'd3 && progValue != 0)
            m_dur[int'(progSel)] = int'(progValue);
      end
      #1;
   endtask

   task automatic test_reset();
      drive_idle();
      reset = 1'b0;
      model_reset();
      tick_edge();
      tick_edge();
      checks++;
      if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
         failures++;
         $display("FAIL reset_hold busy=%b expired=%b remaining=%0d required 0/0/0", busy, expired, remaining);
      end
      #3 reset = 1'b1;
      tick_edge();
      checks++;
      if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
         failures++;
         $display("FAIL reset_release busy=%b expired=%b remaining=%0d required 0/0/0", busy, expired, remaining);
      end
   endtask

   task automatic test_base_sequence();
      int exp_at = -1;
      int pulses = 0;
      drive_idle();
      startTimer = 1'b1;
      tick_edge();
      startTimer = 1'b0;
      checks++;
      if (busy !== 1'b1 || remaining !== W'(6)) begin
         failures++;
         $display("FAIL base_load busy=%b remaining=%0d required 1/6", busy, remaining);
      end
      for (int i = 1; i <= 28; i++) begin
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL base_seq i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
         if (expired === 1'b1) begin
            pulses++;
            if (exp_at < 0) exp_at = i;
         end
      end
      checks++;
      if (exp_at != 24 || pulses != 1) begin
         failures++;
         $display("FAIL base_latency expired_at=%0d pulses=%0d required 24/1", exp_at, pulses);
      end
   endtask

   task automatic test_reprogram();
      int exp_at;
      for (int pass = 0; pass < 2; pass++) begin
         drive_idle();
         reprogram = 1'b1;
         progSel   = 2'd2;
         progValue = (pass == 0) ? W'(5) : W'(0);
         tick_edge();
         drive_idle();
         startTimer    = 1'b1;
         timeParameter = 2'd2;
         tick_edge();
         drive_idle();
         exp_at = -1;
         checks++;
         if (remaining !== W'(5)) begin
            failures++;
            $display("FAIL reprog_load pass=%0d remaining=%0d required 5", pass, remaining);
         end
         for (int i = 1; i <= 24; i++) begin
            tick_edge();
            checks++;
            if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
               failures++;
               $display("FAIL reprog_seq pass=%0d i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                        pass, i, busy, m_active, expired, m_exp, remaining, m_rem());
            end
            if (expired === 1'b1 && exp_at < 0) exp_at = i;
         end
         checks++;
         if (exp_at != 20) begin
            failures++;
            $display("FAIL reprog_latency pass=%0d expired_at=%0d required 20", pass, exp_at);
         end
      end
   endtask

   task automatic test_restart();
      int exp_at = -1;
      int pulses = 0;
      drive_idle();
      startTimer = 1'b1;
      tick_edge();
      for (int i = 1; i <= 30; i++) begin
         startTimer    = (i == 10);
         timeParameter = 2'd1;
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL restart_seq i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
         if (expired === 1'b1) begin
            pulses++;
            if (exp_at < 0) exp_at = i;
         end
      end
      drive_idle();
      checks++;
      if (exp_at != 22 || pulses != 1) begin
         failures++;
         $display("FAIL restart_latency expired_at=%0d pulses=%0d required 22/1", exp_at, pulses);
      end
   endtask

   task automatic test_same_cycle_write();
      drive_idle();
      startTimer = 1'b1;
      reprogram  = 1'b1;
      progSel    = 2'd0;
      progValue  = W'(9);
      tick_edge();
      drive_idle();
      checks++;
      if (remaining !== W'(6)) begin
         failures++;
         $display("FAIL same_cycle_load remaining=%0d required 6", remaining);
      end
      for (int i = 1; i <= 26; i++) begin
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL same_cycle_seq i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
      end
      startTimer = 1'b1;
      tick_edge();
      drive_idle();
      checks++;
      if (remaining !== W'(9)) begin
         failures++;
         $display("FAIL new_base_load remaining=%0d required 9", remaining);
      end
      for (int i = 1; i <= 40; i++) begin
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL new_base_seq i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
      end
   endtask

   task automatic test_async_reset();
      int defaults [3] = '{6, 3, 2};
      drive_idle();
      startTimer = 1'b1;
      tick_edge();
      drive_idle();
      for (int i = 1; i <= 13; i++) tick_edge();
      #2 reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || expired !== 1'b0 || remaining !== '0) begin
         failures++;
         $display("FAIL async_abort busy=%b expired=%b remaining=%0d required 0/0/0", busy, expired, remaining);
      end
      for (int i = 0; i < 3; i++) begin
         tick_edge();
         checks++;
         if (expired !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_in_reset i=%0d busy=%b expired=%b required 0/0", i, busy, expired);
         end
      end
      #3 reset = 1'b1;
      for (int s = 0; s < 3; s++) begin
         startTimer    = 1'b1;
         timeParameter = 2'(s);
         tick_edge();
         checks++;
         if (remaining !== W'(defaults[s])) begin
            failures++;
            $display("FAIL default_dur sel=%0d remaining=%0d required %0d", s, remaining, defaults[s]);
         end
      end
      drive_idle();
      for (int i = 1; i <= 12; i++) begin
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL post_reset_seq i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
      end
   endtask

`ifdef TIMER_PAUSE_EN
   task automatic test_pause();
      int exp_at = -1;
      drive_idle();
      progSel    = 2'd0;
      progValue  = W'(6);
      reprogram  = 1'b1;
      startTimer = 1'b1;
      tick_edge();
      reprogram  = 1'b0;
      startTimer = 1'b1;
      tick_edge();
      drive_idle();
      for (int i = 1; i <= 40; i++) begin
         hold = (i >= 6 && i < 14);
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL pause_seq i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
         if (expired === 1'b1 && exp_at < 0) exp_at = i;
      end
      drive_idle();
      checks++;
      if (exp_at != 32) begin
         failures++;
         $display("FAIL pause_latency expired_at=%0d required 32", exp_at);
      end
   endtask
`endif

   task automatic test_random();
      drive_idle();
      for (int i = 0; i < 1500; i++) begin
         startTimer    = ($urandom_range(0, 24) == 0);
         timeParameter = 2'($urandom_range(0, 3));
         reprogram     = ($urandom_range(0, 9) == 0);
         progSel       = 2'($urandom_range(0, 3));
         progValue     = W'($urandom_range(0, 15));
`ifdef TIMER_PAUSE_EN
         hold          = ($urandom_range(0, 5) == 0);
`endif
         tick_edge();
         checks++;
         if (busy !== m_active || expired !== m_exp || remaining !== W'(m_rem())) begin
            failures++;
            $display("FAIL random i=%0d busy=%b/%b expired=%b/%b remaining=%0d/%0d",
                     i, busy, m_active, expired, m_exp, remaining, m_rem());
         end
      end
      drive_idle();
   endtask

   initial begin
      drive_idle();
      reset = 1'b0;
      test_reset();
      test_base_sequence();
      test_reprogram();
      test_restart();
      test_same_cycle_write();
      test_async_reset();
`ifdef TIMER_PAUSE_EN
      test_pause();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
